// File: rtl/demux1x2_stream_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer: port encodings,
// default widths and FIFO geometry.
package demux1x2_stream_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CNT_W = 8;
    localparam int unsigned FIFO_DEPTH    = 2;
    localparam int unsigned OCC_W         = 2;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

endpackage

// File: rtl/demux1x2_stream_fifo2.sv
// Two-entry FIFO with a registered head word, registered valid/full flags,
// and an occupancy output.
module fifo2
    import demux1x2_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic             wptr_q;
    logic             wptr_d;
    logic             rptr_q;
    logic             rptr_d;
    logic [OCC_W-1:0] occ_d;
    logic [WIDTH-1:0] head_d;
    logic             push_ok;
    logic             pop_ok;

    // Next state; the head is taken from the post-update storage so the
    // output register always shows the oldest word one cycle after a push.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        occ_d   = occ;
        push_ok = push && !full;
        pop_ok  = pop && valid;

        if (push_ok) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = ~wptr_q;
        end
        if (pop_ok) begin
            rptr_d = ~rptr_q;
        end

        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ + OCC_W'(1);
            2'b01:   occ_d = occ - OCC_W'(1);
            default: occ_d = occ;
        endcase

        head_d = mem_d[rptr_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            occ    <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
            rdata  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ    <= occ_d;
            valid  <= (occ_d != '0);
            full   <= (occ_d == OCC_W'(FIFO_DEPTH));
            rdata  <= head_d;
        end
    end

endmodule

// File: rtl/demux1x2_stream.sv
// 1-to-2 stream demultiplexer: steers each input word into one of two
// independent 2-entry FIFOs and counts words delivered per port.
module demux1x2_stream
    import demux1x2_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             full0,
    output logic             full1
);

    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;
    logic [OCC_W-1:0] occ0;
    logic [OCC_W-1:0] occ1;
    logic             sel_full;

    // Back-pressure only from the selected port, so a full port never
    // stalls traffic aimed at the other one.
    always_comb begin
        sel_full = (in_sel == PORT1) ? (occ1 == OCC_W'(FIFO_DEPTH))
                                     : (occ0 == OCC_W'(FIFO_DEPTH));
        in_ready = !sel_full;
        push0    = in_valid && in_ready && (in_sel == PORT0);
        push1    = in_valid && in_ready && (in_sel == PORT1);
        pop0     = out0_valid && out0_ready;
        pop1     = out1_valid && out1_ready;
    end

    fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .pop   (pop0),
        .wdata (in_data),
        .rdata (out0_data),
        .valid (out0_valid),
        .full  (full0),
        .occ   (occ0)
    );

    fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .pop   (pop1),
        .wdata (in_data),
        .rdata (out1_data),
        .valid (out1_valid),
        .full  (full1),
        .occ   (occ1)
    );

    // Delivered-word counters, wrapping silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (pop1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule
